// File: rtl/dm_access_ctrl_if.sv
// rtl/dm_access_ctrl_if.sv - request/response and data-memory port bundle for dm_access_ctrl
interface dm_access_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-3:0] dm_A;
  logic [3:0]        dm_BE;
  logic [31:0]       dm_WD;
  logic              dm_We;
  logic [31:0]       dm_RD;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, dm_RD,
    output req_ready, resp_valid, resp_rdata, resp_err, dm_A, dm_BE, dm_WD, dm_We
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, dm_RD,
    input  req_ready, resp_valid, resp_rdata, resp_err, dm_A, dm_BE, dm_WD, dm_We
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - single-outstanding load/store initiator for the byte-enabled data memory
module dm_access_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  dm_access_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RESP, S_ERR} state_e;

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-3:0] dm_a_q, dm_a_d;
  logic [31:0]       dm_wd_q, dm_wd_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic              dm_we_q, dm_we_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic              req_err;
  logic [3:0]        req_be;
  logic [31:0]       req_wd;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;

  // Request decode: legality, lane enables and replicated store data.
  always_comb begin
    req_err = (bus.req_size == 2'b11)
            | ((bus.req_size == 2'b01) & bus.req_addr[0])
            | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]))
            | (|bus.req_addr[31:ADDR_W]);
    case (bus.req_size)
      2'b00:   req_be = 4'b0001 << bus.req_addr[1:0];
      2'b01:   req_be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      default: req_be = 4'b1111;
    endcase
    case (bus.req_size)
      2'b00:   req_wd = {4{bus.req_wdata[7:0]}};
      2'b01:   req_wd = {2{bus.req_wdata[15:0]}};
      default: req_wd = bus.req_wdata;
    endcase
  end

  // Read-lane alignment and extension from the captured request attributes.
  always_comb begin
    rd_byte = bus.dm_RD[{lane_q, 3'b000} +: 8];
    rd_half = bus.dm_RD[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = sgn_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      2'b01:   load_ext = sgn_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      default: load_ext = bus.dm_RD;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    dm_a_d       = dm_a_q;
    dm_wd_d      = dm_wd_q;
    dm_be_d      = 4'b0000;
    dm_we_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          lane_d  = bus.req_addr[1:0];
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          dm_a_d  = bus.req_addr[ADDR_W-1:2];
          dm_wd_d = req_wd;
          cnt_d   = 2'd0;
          if (req_err) begin
            state_d      = S_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus.req_we) begin
            state_d = S_WRITE;
            dm_we_d = 1'b1;
            dm_be_d = req_be;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      // Counts out the memory latency; the final READ cycle captures dm_RD.
      S_READ: begin
        if (cnt_q == LAT) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      lane_q       <= 2'd0;
      size_q       <= 2'd0;
      sgn_q        <= 1'b0;
      dm_a_q       <= '0;
      dm_wd_q      <= 32'h0;
      dm_be_q      <= 4'b0000;
      dm_we_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      dm_a_q       <= dm_a_d;
      dm_wd_q      <= dm_wd_d;
      dm_be_q      <= dm_be_d;
      dm_we_q      <= dm_we_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.dm_A       = dm_a_q;
  assign bus.dm_BE      = dm_be_q;
  assign bus.dm_WD      = dm_wd_q;
  assign bus.dm_We      = dm_we_q;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - randomized and directed bench for dm_access_ctrl against a byte-array model
module tb_dm_access_ctrl;
  localparam int ADDR_W = 12;
  localparam int LAT    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  dm_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dm_access_ctrl #(.ADDR_W(ADDR_W), .RD_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Synchronous-read memory stub with byte-lane writes.
  bit [31:0] mem_w [1024];
  bit [31:0] rd_pipe [2];
  always @(posedge clk) begin
    if (bus.dm_We) begin
      for (int i = 0; i < 4; i++)
        if (bus.dm_BE[i]) mem_w[bus.dm_A][8*i +: 8] <= bus.dm_WD[8*i +: 8];
    end
    rd_pipe[0] <= mem_w[bus.dm_A];
    rd_pipe[1] <= rd_pipe[0];
  end
  assign bus.dm_RD = rd_pipe[LAT-1];

  // Reference model: flat byte-addressed memory.
  byte unsigned ref_mem [4096];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] addr, input logic [1:0] size);
    return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0)
           || (addr >= 32'(1 << ADDR_W));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n, input bit sgn);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
    if (sgn && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input bit sgn, input logic [31:0] wdata);
    bit err, seen, we_seen;
    int n, exp_k, k;
    logic [31:0] exp_rd, exp_be, exp_wd;
    err    = model_err(addr, size);
    n      = 1 << size;
    exp_rd = (!err && !we) ? model_load(addr, n, sgn) : 32'h0;
    exp_k  = err ? 1 : (we ? 2 : 2 + LAT);
    exp_be = 32'(((1 << n) - 1) << (addr % 4));
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % n) +: 8];
    @(negedge clk);
    chk("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_size = size; bus.req_signed = sgn; bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    seen = 0; we_seen = 0; k = 1;
    while (k <= 8 && !seen) begin
      if (k > 1) @(negedge clk);
      if (k == 1 && we && !err) begin
        chk("wr_we", 32'(bus.dm_We), 32'd1);
        chk("wr_be", 32'(bus.dm_BE), exp_be);
        chk("wr_wd", bus.dm_WD, exp_wd);
        chk("wr_a", 32'(bus.dm_A), (addr / 4) % 1024);
      end else if (bus.dm_We) we_seen = 1;
      if (bus.resp_valid) begin
        seen = 1;
        chk("resp_lat", 32'(k), 32'(exp_k));
        chk("resp_err", 32'(bus.resp_err), 32'(err));
        chk("resp_rdata", bus.resp_rdata, exp_rd);
      end
      k++;
    end
    if (!seen) chk("resp_timeout", 32'd0, 32'd1);
    chk("no_extra_we", 32'(we_seen), 32'd0);
    if (we && !err)
      for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
    @(negedge clk);
    chk("resp_clear", {30'h0, bus.resp_valid, bus.resp_err}, 32'h0);
    chk("rdata_clear", bus.resp_rdata, 32'h0);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0;
    bus.req_size = 0; bus.req_signed = 0; bus.req_wdata = 0;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_outs", {bus.dm_WD ^ 32'(bus.dm_A), 28'h0, bus.dm_BE}, 60'h0 >> 28);
    chk("rst_ctl", {29'h0, bus.dm_We, bus.resp_valid, bus.resp_err}, 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed scenarios.
    do_req(1, 32'h010, 2'b10, 0, 32'hDEADBEEF);
    do_req(1, 32'h013, 2'b00, 0, 32'h000000A5);
    do_req(0, 32'h013, 2'b00, 1, 32'h0);
    do_req(0, 32'h013, 2'b00, 0, 32'h0);
    do_req(1, 32'h010, 2'b10, 0, 32'h80010000);
    do_req(0, 32'h012, 2'b01, 1, 32'h0);
    do_req(0, 32'h012, 2'b01, 0, 32'h0);
    do_req(0, 32'h010, 2'b01, 1, 32'h0);
    do_req(1, 32'h002, 2'b10, 0, 32'h12345678);
    do_req(0, 32'h1000, 2'b01, 0, 32'h0);
    do_req(1, 32'h020, 2'b11, 0, 32'hFFFFFFFF);

    // Back-to-back loads with req_valid held high.
    begin
      int k;
      bit got_ready;
      logic [31:0] exp_rd;
      exp_rd = model_load(32'h010, 4, 0);
      @(negedge clk);
      bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h010;
      bus.req_size = 2'b10; bus.req_signed = 0;
      @(posedge clk);
      got_ready = 0; k = 0;
      while (k < 10 && !got_ready) begin
        @(negedge clk);
        k++;
        if (bus.req_ready) got_ready = 1;
        if (bus.resp_valid) chk("b2b_first_rdata", bus.resp_rdata, exp_rd);
      end
      chk("b2b_ready_cycle", 32'(k), 32'(3 + LAT));
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 0;
      chk("b2b_busy", 32'(bus.req_ready), 32'd0);
      repeat (LAT) @(negedge clk);
      @(negedge clk);
      chk("b2b_second_resp", 32'(bus.resp_valid), 32'd1);
      chk("b2b_second_rdata", bus.resp_rdata, exp_rd);
    end

    // Reset in the middle of a write.
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h030;
    bus.req_size = 2'b10; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    chk("midwr_we_before", 32'(bus.dm_We), 32'd1);
    rst = 1'b1;
    #1;
    chk("midwr_we_after", 32'(bus.dm_We), 32'd0);
    chk("midwr_be_after", 32'(bus.dm_BE), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_req(0, 32'h030, 2'b10, 0, 32'h0);

    // Reset in the middle of a read.
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h010;
    bus.req_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    rst = 1'b1;
    #1;
    chk("midrd_ready", 32'(bus.req_ready), 32'd1);
    chk("midrd_a", 32'(bus.dm_A), 32'd0);
    chk("midrd_outs", {bus.resp_rdata | bus.dm_WD}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    begin
      bit any_resp = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.resp_valid) any_resp = 1;
      end
      chk("midrd_no_resp", 32'(any_resp), 32'd0);
    end

    // Randomized traffic against the model.
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)      a = 32'h1000 + $urandom_range(0, 255);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, 63);
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~32'((1 << sz) - 1);
      do_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
